// File: rtl/axis_slave_fifo.sv
// AXI4-Stream slave with a DEPTH-entry first-word-fall-through FIFO.
// Carries keep/last/user with each beat, discards null beats, and reports level and packet count.
module axis_slave_fifo #(
    parameter int unsigned TDATA_WIDTH = 512,
    parameter int unsigned TUSER_WIDTH = 8,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned AFULL_LEVEL = DEPTH - 2
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       tvalid,
    input  logic [TDATA_WIDTH-1:0]     tdata,
    input  logic [TDATA_WIDTH/8-1:0]   tkeep,
    input  logic                       tlast,
    input  logic [TUSER_WIDTH-1:0]     tuser,
    output logic                       tready,
    output logic                       out_valid,
    output logic [TDATA_WIDTH-1:0]     out_data,
    output logic [TDATA_WIDTH/8-1:0]   out_keep,
    output logic                       out_last,
    output logic [TUSER_WIDTH-1:0]     out_user,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     level,
    output logic [$clog2(DEPTH):0]     pkt_count,
    output logic                       almost_full,
    output logic                       null_drop
);

    localparam int unsigned KW = TDATA_WIDTH / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;
    localparam int unsigned EW = TDATA_WIDTH + KW + 1 + TUSER_WIDTH;

    logic [EW-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] level_q;
    logic [LW-1:0] pkt_q;
    logic          full_q;
    logic          nonempty_q;
    logic          afull_q;
    logic          null_q;

    logic          push_c;
    logic          is_null_c;
    logic          store_c;
    logic          pop_c;
    logic [EW-1:0] head_c;
    logic [LW-1:0] level_nxt_c;
    logic [LW-1:0] pkt_nxt_c;

    // Handshake decode; tready depends only on aresetn and registered fill state.
    assign tready      = aresetn & ~full_q;
    assign out_valid   = aresetn & nonempty_q;
    assign almost_full = aresetn & afull_q;
    assign level       = level_q;
    assign pkt_count   = pkt_q;
    assign null_drop   = null_q;

    assign push_c    = tvalid & tready;
    assign is_null_c = (tkeep == '0) & ~tlast;
    assign store_c   = push_c & ~is_null_c;
    assign pop_c     = out_valid & out_ready;

    assign head_c   = mem[rd_ptr];
    assign out_data = head_c[EW-1 -: TDATA_WIDTH];
    assign out_keep = head_c[TUSER_WIDTH+1 +: KW];
    assign out_last = head_c[TUSER_WIDTH];
    assign out_user = head_c[TUSER_WIDTH-1:0];

    // Next fill level and stored-packet count; simultaneous in/out events cancel.
    always_comb begin
        level_nxt_c = level_q;
        pkt_nxt_c   = pkt_q;
        case ({store_c, pop_c})
            2'b10:   level_nxt_c = level_q + LW'(1);
            2'b01:   level_nxt_c = level_q - LW'(1);
            default: level_nxt_c = level_q;
        endcase
        case ({store_c & tlast, pop_c & out_last})
            2'b10:   pkt_nxt_c = pkt_q + LW'(1);
            2'b01:   pkt_nxt_c = pkt_q - LW'(1);
            default: pkt_nxt_c = pkt_q;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            level_q    <= '0;
            pkt_q      <= '0;
            full_q     <= 1'b0;
            nonempty_q <= 1'b0;
            afull_q    <= 1'b0;
            null_q     <= 1'b0;
        end else begin
            if (store_c) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_c) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            level_q    <= level_nxt_c;
            pkt_q      <= pkt_nxt_c;
            full_q     <= (level_nxt_c == LW'(DEPTH));
            nonempty_q <= (level_nxt_c != '0);
            afull_q    <= (level_nxt_c >= LW'(AFULL_LEVEL));
            null_q     <= push_c & is_null_c;
        end
    end

    // Storage array is intentionally not reset.
    always_ff @(posedge aclk) begin
        if (store_c) begin
            mem[wr_ptr] <= {tdata, tkeep, tlast, tuser};
        end
    end

endmodule

// File: doc/axis_slave_fifo.md
Name: axis_slave_fifo

Overview:
Parametrised AXI4-Stream slave with an internal FIFO. It replaces the single-register capture stage with a DEPTH-entry buffer and full valid/ready backpressure on both sides. The block carries tkeep/tlast/tuser alongside tdata, discards AXI null beats, and reports fill level and complete-packet count. It sits between an AXI-Stream master (DMA or MAC front end) and the internal authentication datapath.

Parameters:
TDATA_WIDTH, 512, data bus width in bits; must be a multiple of 8
TUSER_WIDTH, 8, sideband user width
DEPTH, 8, FIFO entries; power of 2, 2..256
AFULL_LEVEL, DEPTH-2, almost_full asserts when count >= AFULL_LEVEL

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  synchronous active-low reset
tvalid  in  1  AXI master beat valid
tdata  in  TDATA_WIDTH  AXI beat data
tkeep  in  TDATA_WIDTH/8  byte-keep mask
tlast  in  1  packet end marker
tuser  in  TUSER_WIDTH  sideband
tready  out  1  slave ready
out_valid  out  1  internal head beat valid
out_data  out  TDATA_WIDTH  head data
out_keep  out  TDATA_WIDTH/8  head keep
out_last  out  1  head last
out_user  out  TUSER_WIDTH  head user
out_ready  in  1  internal consumer ready
level  out  $clog2(DEPTH)+1  stored beat count, 0..DEPTH
pkt_count  out  $clog2(DEPTH)+1  stored beats with last=1
almost_full  out  1  level >= AFULL_LEVEL
null_drop  out  1  one-cycle pulse when a null beat is discarded

Behaviour:
- Reset is sampled only on posedge aclk while aresetn=0. It clears the write pointer, read pointer, level and pkt_count to 0, and clears null_drop.
- During reset and for the whole reset cycle: tready=0, out_valid=0, almost_full=0. FIFO RAM contents are not reset; out_data/keep/last/user are don't-care while out_valid=0.
- tready = aresetn & (level != DEPTH), decoded from registered state only. tready has no combinational path from tvalid or out_ready.
- Push (accept) occurs when tvalid & tready. Pop occurs when out_valid & out_ready.
- Null beat: an accepted beat with tkeep == 0 and tlast == 0 is discarded and not stored. null_drop pulses high the next cycle. A beat with tkeep == 0 and tlast == 1 is stored, because it carries packet termination.
- First-word fall-through: out_* present entry[rd_ptr] whenever level > 0, and out_valid = (level != 0).
- Latency: a beat accepted at edge N appears on out_* with out_valid=1 after edge N (1 cycle) when the FIFO was empty.
- Order is strictly preserved. out_* stay stable while out_valid & !out_ready.
- Pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- level update: +1 on store only, -1 on pop only, unchanged on simultaneous store and pop.
- pkt_count update: +1 when the stored beat has tlast=1, -1 when the popped beat has out_last=1. Both events in one cycle leave it unchanged.
- Full (level == DEPTH): tready=0, so a pop in the same cycle does not enable a same-cycle push. The push is accepted the following cycle.
- Empty (level == 0): out_valid=0 and out_ready is ignored. A push and a pop request in the same cycle on an empty FIFO produce push only.
- Reset mid-packet: all stored beats are flushed. Partial packets are lost and not re-emitted, and the master must restart.
- almost_full and level are registered-state decodes, valid the cycle after the causing edge.
- tstrb, tid, tdest and twakeup are not supported. Width conversion is not supported.

Test Plan:
- Reset: hold aresetn=0 for 3 cycles with tvalid=1 -> tready=0, out_valid=0, level=0, and no beat stored. First cycle after release -> tready=1.
- Fill and drain, DEPTH=8, out_ready=0: push 8 beats with data 0..7 -> level=8, tready=0 after the 8th. Then set out_ready=1 -> out_data reads 0..7 in order, one per cycle, and level returns to 0.
- Simultaneous traffic: tvalid=1 and out_ready=1 continuously for 100 beats -> throughput 1 beat/cycle after the 1-cycle fill, level holds at 1, and every beat is matched.
- Full boundary: at level=8, pulse out_ready=1 for one cycle with tvalid=1 -> pop occurs, level=7, tready=1 the next cycle, and the pending beat is accepted then.
- Null beats: send keep=0/last=0, keep=FF../last=0, keep=0/last=1 -> the first is dropped with a null_drop pulse, the other two are stored, level=2 and pkt_count=1.
- Wrap and mid-packet reset: push and pop 20 beats across the pointer wrap and check order. Then stop at level=3 with an open packet and assert aresetn=0 for 1 cycle -> level=0, pkt_count=0, out_valid=0.
